// File: rtl/des_framer_pkg.sv
// Shared types and constants for the DES byte/block framer.
// State encodings plus block width; no logic.
package des_framer_pkg;
  localparam int BLOCK_BITS = 64;

  typedef enum logic [1:0] {
    S_COLLECT = 2'd0,
    S_START   = 2'd1,
    S_WAIT    = 2'd2,
    S_SEND    = 2'd3
  } state_t;
endpackage

// File: rtl/generic_register.sv
// Enabled register with synchronous active-high reset to a parameterised value.
// One cycle latency from d/en to q; no backpressure.
module generic_register #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk) begin
    if (rst) q <= RST_VAL;
    else if (en) q <= d;
  end
endmodule

// File: rtl/des_block_framer.sv
// Packs 8 SPI bytes into a DES block, starts the core, returns the ciphertext as 8 bytes.
// Start one cycle after 8th byte; output valid one cycle after done; bytes held until out_ready.
module des_block_framer
  import des_framer_pkg::*;
#(
  parameter int NUM_BYTES = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_byte,
  input  logic                  rx_valid,
  output logic [7:0]            out_byte,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  des_start,
  output logic [BLOCK_BITS-1:0] des_plaintext,
  input  logic                  des_busy,
  input  logic                  des_done,
  input  logic [BLOCK_BITS-1:0] des_ciphertext,
  output logic                  busy,
  output logic [2:0]            byte_count,
  output logic                  overrun,
  input  logic                  overrun_clr
);
  localparam logic [2:0] LAST_IDX = 3'(NUM_BYTES - 1);

  logic [1:0]            state_raw_q;
  state_t                state_q, state_d;
  logic [2:0]            cnt_q, cnt_d;
  logic                  cnt_en;
  logic [BLOCK_BITS-1:0] pt_q, pt_d;
  logic                  pt_en;
  logic [BLOCK_BITS-1:0] out_q, out_d;
  logic                  out_en;
  logic                  ovr_q, ovr_d;

  // The core's busy flag is informational only; sequencing relies on done.
  logic unused_des_busy;
  assign unused_des_busy = des_busy;

  assign state_q = state_t'(state_raw_q);

  generic_register #(.W(2), .RST_VAL(2'(S_COLLECT))) u_state (
    .clk(clk), .rst(rst), .en(1'b1), .d(2'(state_d)), .q(state_raw_q)
  );
  generic_register #(.W(3)) u_count (
    .clk(clk), .rst(rst), .en(cnt_en), .d(cnt_d), .q(cnt_q)
  );
  generic_register #(.W(BLOCK_BITS)) u_plaintext (
    .clk(clk), .rst(rst), .en(pt_en), .d(pt_d), .q(pt_q)
  );
  generic_register #(.W(BLOCK_BITS)) u_out (
    .clk(clk), .rst(rst), .en(out_en), .d(out_d), .q(out_q)
  );
  generic_register #(.W(1)) u_overrun (
    .clk(clk), .rst(rst), .en(1'b1), .d(ovr_d), .q(ovr_q)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cnt_en    = 1'b0;
    pt_d      = {pt_q[BLOCK_BITS-9:0], rx_byte};
    pt_en     = 1'b0;
    out_d     = {out_q[BLOCK_BITS-9:0], 8'h00};
    out_en    = 1'b0;
    ovr_d     = ovr_q & ~overrun_clr;
    des_start = (state_q == S_START);
    out_valid = (state_q == S_SEND);
    busy      = (state_q != S_COLLECT);

    case (state_q)
      S_COLLECT: begin
        if (rx_valid) begin
          pt_en  = 1'b1;
          cnt_en = 1'b1;
          if (cnt_q == LAST_IDX) begin
            cnt_d   = 3'd0;
            state_d = S_START;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      S_START: state_d = S_WAIT;
      S_WAIT: begin
        if (des_done) begin
          out_d   = des_ciphertext;
          out_en  = 1'b1;
          cnt_d   = 3'd0;
          cnt_en  = 1'b1;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (out_ready) begin
          out_en = 1'b1;
          cnt_en = 1'b1;
          if (cnt_q == LAST_IDX) begin
            cnt_d   = 3'd0;
            state_d = S_COLLECT;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      default: state_d = S_COLLECT;
    endcase

    // A drop in the same cycle as a clear must leave the flag set.
    if (rx_valid && (state_q != S_COLLECT)) ovr_d = 1'b1;
  end

  assign des_plaintext = pt_q;
  assign out_byte      = out_q[BLOCK_BITS-1 -: 8];
  assign byte_count    = cnt_q;
  assign overrun       = ovr_q;
endmodule

// File: tb/tb_des_block_framer.sv
// Randomised bench for des_block_framer with a byte-history / ciphertext-byte reference model.
module tb_des_block_framer;
  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic [7:0]  out_byte;
  logic        out_valid;
  logic        out_ready;
  logic        des_start;
  logic [63:0] des_plaintext;
  logic        des_busy;
  logic        des_done;
  logic [63:0] des_ciphertext;
  logic        busy;
  logic [2:0]  byte_count;
  logic        overrun;
  logic        overrun_clr;

  always #5 clk = ~clk;

  des_block_framer #(.NUM_BYTES(8)) dut (
    .clk(clk), .rst(rst), .rx_byte(rx_byte), .rx_valid(rx_valid),
    .out_byte(out_byte), .out_valid(out_valid), .out_ready(out_ready),
    .des_start(des_start), .des_plaintext(des_plaintext), .des_busy(des_busy),
    .des_done(des_done), .des_ciphertext(des_ciphertext), .busy(busy),
    .byte_count(byte_count), .overrun(overrun), .overrun_clr(overrun_clr)
  );

  // Model: every byte accepted since reset, and the expected sticky overrun flag.
  logic [7:0] hist[$];
  bit         ovr_m;
  int         checks = 0;
  int         errors = 0;

  function automatic logic [63:0] exp_pt();
    logic [63:0] r = '0;
    int n = hist.size();
    int lo = (n > 8) ? n - 8 : 0;
    for (int i = lo; i < n; i++) r[8*(n-1-i) +: 8] = hist[i];
    return r;
  endfunction

  function automatic logic [7:0] nth_byte(input logic [63:0] v, input int k);
    return v[63-8*k -: 8];
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    rx_byte = b; rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    hist.push_back(b);
  endtask

  task automatic fill(input logic [63:0] blk, input int from);
    for (int i = from; i < 8; i++) begin
      push_byte(nth_byte(blk, i));
      if (i < 7) begin
        checks++;
        if (byte_count !== 3'(i + 1) || busy !== 1'b0) begin
          errors++;
          $display("FAIL collect_count byte %0d: count=%0d busy=%b, want count=%0d busy=0",
                   i, byte_count, busy, i + 1);
        end
      end
    end
    checks++;
    if (des_start !== 1'b1 || busy !== 1'b1 || byte_count !== 3'd0 || des_plaintext !== exp_pt()) begin
      errors++;
      $display("FAIL start_cycle: start=%b busy=%b count=%0d pt=%h, want 1 1 0 %h",
               des_start, busy, byte_count, des_plaintext, exp_pt());
    end
    tick();
    checks++;
    if (des_start !== 1'b0 || busy !== 1'b1 || des_plaintext !== exp_pt()) begin
      errors++;
      $display("FAIL start_pulse_width: start=%b busy=%b pt=%h, want 0 1 %h",
               des_start, busy, des_plaintext, exp_pt());
    end
  endtask

  task automatic done_pulse(input logic [63:0] ct, input int wait_cyc);
    des_busy = 1'b1;
    for (int w = 0; w < wait_cyc; w++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL wait_state: out_valid=%b busy=%b, want 0 1", out_valid, busy);
      end
    end
    des_ciphertext = ct; des_done = 1'b1;
    tick();
    des_done = 1'b0; des_busy = 1'b0; des_ciphertext = rnd64();
  endtask

  // mode 0: ready always, 1: ready every third cycle, 2: random ready
  task automatic send_out(input logic [63:0] ct, input int mode, input bit rx_on_last);
    int k = 0;
    int cyc = 0;
    while (k < 8 && cyc < 200) begin
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (cyc % 3 == 2);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      checks++;
      if (out_valid !== 1'b1 || out_byte !== nth_byte(ct, k) || byte_count !== 3'(k)) begin
        errors++;
        $display("FAIL send_byte %0d: valid=%b byte=%h count=%0d, want 1 %h %0d",
                 k, out_valid, out_byte, byte_count, nth_byte(ct, k), k);
      end
      if (rx_on_last && out_ready && k == 7) begin
        rx_byte = 8'($urandom); rx_valid = 1'b1; ovr_m = 1'b1;
      end
      tick();
      rx_valid = 1'b0;
      if (out_ready) k++;
      cyc++;
    end
    out_ready = 1'b0;
    checks++;
    if (k != 8) begin
      errors++;
      $display("FAIL send_timeout: accepted %0d bytes, want 8", k);
    end
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || byte_count !== 3'd0 || overrun !== ovr_m) begin
      errors++;
      $display("FAIL send_end: busy=%b valid=%b count=%0d overrun=%b, want 0 0 0 %b",
               busy, out_valid, byte_count, overrun, ovr_m);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    hist.delete(); ovr_m = 1'b0;
    checks++;
    if ({des_start, out_valid, busy, overrun, byte_count, out_byte, des_plaintext} !== 79'd0) begin
      errors++;
      $display("FAIL reset_values: start=%b valid=%b busy=%b ovr=%b cnt=%0d byte=%h pt=%h, want all 0",
               des_start, out_valid, busy, overrun, byte_count, out_byte, des_plaintext);
    end
  endtask

  task automatic test_known_vector();
    fill(64'h0123456789ABCDEF, 0);
    checks++;
    if (des_plaintext !== 64'h0123456789ABCDEF) begin
      errors++;
      $display("FAIL known_plaintext: got %h want 0123456789abcdef", des_plaintext);
    end
    done_pulse(64'h85E813540F0AB405, 2);
    send_out(64'h85E813540F0AB405, 0, 1'b0);
  endtask

  task automatic test_throttle();
    logic [63:0] ct = rnd64();
    fill(rnd64(), 0);
    done_pulse(ct, int'($urandom_range(0, 4)));
    send_out(ct, 1, 1'b0);
  endtask

  task automatic test_overrun();
    logic [63:0] ct = rnd64();
    fill(rnd64(), 0);
    rx_byte = 8'($urandom); rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0; ovr_m = 1'b1;
    checks++;
    if (overrun !== 1'b1 || des_plaintext !== exp_pt()) begin
      errors++;
      $display("FAIL drop_in_wait: overrun=%b pt=%h, want 1 %h", overrun, des_plaintext, exp_pt());
    end
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0; ovr_m = 1'b0;
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL clear_alone_wait: overrun=%b want 0", overrun);
    end
    done_pulse(ct, 0);
    out_ready = 1'b0;
    rx_byte = 8'($urandom); rx_valid = 1'b1; overrun_clr = 1'b1;
    tick();
    rx_valid = 1'b0; overrun_clr = 1'b0; ovr_m = 1'b1;
    checks++;
    if (overrun !== 1'b1 || des_plaintext !== exp_pt() || out_byte !== nth_byte(ct, 0)) begin
      errors++;
      $display("FAIL drop_with_clear_send: overrun=%b pt=%h byte=%h, want 1 %h %h",
               overrun, des_plaintext, out_byte, exp_pt(), nth_byte(ct, 0));
    end
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0; ovr_m = 1'b0;
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL clear_alone_send: overrun=%b want 0", overrun);
    end
    send_out(ct, 2, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [63:0] ct  = rnd64();
    logic [63:0] ct2 = rnd64();
    logic [63:0] blk = rnd64();
    fill(rnd64(), 0);
    done_pulse(ct, 0);
    send_out(ct, 0, 1'b1);
    push_byte(nth_byte(blk, 0));
    checks++;
    if (byte_count !== 3'd1 || overrun !== 1'b1) begin
      errors++;
      $display("FAIL collect_after_send: count=%0d overrun=%b, want 1 1", byte_count, overrun);
    end
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0; ovr_m = 1'b0;
    fill(blk, 1);
    done_pulse(ct2, 1);
    send_out(ct2, 0, 1'b0);
  endtask

  task automatic test_spurious_done();
    logic [63:0] blk = rnd64();
    logic [63:0] ct  = rnd64();
    for (int i = 0; i < 3; i++) push_byte(nth_byte(blk, i));
    des_ciphertext = rnd64(); des_done = 1'b1;
    tick();
    des_done = 1'b0;
    checks++;
    if (byte_count !== 3'd3 || out_valid !== 1'b0 || busy !== 1'b0 || des_start !== 1'b0) begin
      errors++;
      $display("FAIL spurious_done: count=%0d valid=%b busy=%b start=%b, want 3 0 0 0",
               byte_count, out_valid, busy, des_start);
    end
    fill(blk, 3);
    checks++;
    if (des_plaintext !== blk) begin
      errors++;
      $display("FAIL spurious_block: pt=%h want %h", des_plaintext, blk);
    end
    done_pulse(ct, 0);
    send_out(ct, 2, 1'b0);
  endtask

  task automatic test_random_blocks();
    for (int b = 0; b < 6; b++) begin
      logic [63:0] ct = rnd64();
      fill(rnd64(), 0);
      done_pulse(ct, int'($urandom_range(0, 5)));
      send_out(ct, int'($urandom_range(0, 2)), 1'b0);
    end
  endtask

  task automatic test_reset_mid();
    logic [63:0] ct = rnd64();
    logic [63:0] blk = rnd64();
    for (int i = 0; i < 5; i++) push_byte(nth_byte(blk, i));
    rst = 1'b1;
    tick();
    rst = 1'b0; hist.delete(); ovr_m = 1'b0;
    checks++;
    if ({des_start, out_valid, busy, overrun, byte_count, out_byte, des_plaintext} !== 79'd0) begin
      errors++;
      $display("FAIL reset_in_collect: cnt=%0d busy=%b pt=%h byte=%h, want all 0",
               byte_count, busy, des_plaintext, out_byte);
    end
    fill(rnd64(), 0);
    done_pulse(ct, 1);
    out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (out_valid !== 1'b1 || out_byte !== nth_byte(ct, k)) begin
        errors++;
        $display("FAIL pre_reset_send %0d: valid=%b byte=%h, want 1 %h",
                 k, out_valid, out_byte, nth_byte(ct, k));
      end
      tick();
    end
    out_ready = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0; hist.delete(); ovr_m = 1'b0;
    checks++;
    if ({des_start, out_valid, busy, overrun, byte_count, out_byte, des_plaintext} !== 79'd0) begin
      errors++;
      $display("FAIL reset_in_send: valid=%b cnt=%0d busy=%b byte=%h pt=%h, want all 0",
               out_valid, byte_count, busy, out_byte, des_plaintext);
    end
    des_ciphertext = rnd64(); des_done = 1'b1;
    tick();
    des_done = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || byte_count !== 3'd0) begin
      errors++;
      $display("FAIL late_done: valid=%b busy=%b count=%0d, want 0 0 0", out_valid, busy, byte_count);
    end
    ct = rnd64();
    fill(rnd64(), 0);
    done_pulse(ct, 0);
    send_out(ct, 0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; rx_byte = 8'h00; rx_valid = 1'b0; out_ready = 1'b0;
    des_busy = 1'b0; des_done = 1'b0; des_ciphertext = 64'h0; overrun_clr = 1'b0;
    test_reset();
    test_known_vector();
    test_throttle();
    test_overrun();
    test_back_to_back();
    test_spurious_done();
    test_random_blocks();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
